// File: rtl/response_encoder.sv
// Turns completed register-bus transactions into ASCII replies on an 8-bit AXI-Stream master:
// reads become hex digits MSB first plus LF, writes become "ok" plus LF.
module response_encoder #(
  parameter int WORD_SIZE = 32,
  parameter bit UPPERCASE = 1'b0,
  parameter bit WRITE_ACK = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Cs,
  input  logic                 We,
  input  logic                 Ack,
  input  logic [WORD_SIZE-1:0] Rdata,
  output logic                 M_axis_tvalid,
  output logic [7:0]           M_axis_tdata,
  input  logic                 M_axis_tready,
  output logic                 Busy,
  output logic                 Overrun
);

  localparam int DIGITS = WORD_SIZE / 4;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HEX,
    SEND_OK,
    SEND_LF
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ok_idx_q, ok_idx_d;
  logic                 overrun_q, overrun_d;

  logic                 done;
  logic                 xfer;
  logic [3:0]           nib;
  logic [7:0]           tdata_c;
  logic [3:0]           nib_a [DIGITS];

  // Slice the frozen word into nibbles; the digit counter then picks one.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib_a[gi] = data_q[4*gi +: 4];
    end
  endgenerate

  assign done = Cs & Ack;
  assign xfer = M_axis_tvalid & M_axis_tready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    ok_idx_d  = ok_idx_q;
    tdata_c   = 8'h00;
    nib       = nib_a[cnt_q];
    overrun_d = done & (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (done) begin
          if (!We) begin
            data_d  = Rdata;
            cnt_d   = LAST_DIGIT;
            state_d = SEND_HEX;
          end else if (WRITE_ACK) begin
            ok_idx_d = 1'b0;
            state_d  = SEND_OK;
          end
        end
      end
      SEND_HEX: begin
        if (nib < 4'd10) tdata_c = 8'h30 + {4'h0, nib};
        else             tdata_c = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
        if (xfer) begin
          if (cnt_q == '0) state_d = SEND_LF;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      SEND_OK: begin
        tdata_c = ok_idx_q ? 8'h6B : 8'h6F;
        if (xfer) begin
          if (ok_idx_q) state_d  = SEND_LF;
          else          ok_idx_d = 1'b1;
        end
      end
      SEND_LF: begin
        tdata_c = 8'h0A;
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      ok_idx_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      ok_idx_q  <= ok_idx_d;
      overrun_q <= overrun_d;
    end
  end

  // All outputs come straight from registers, so tvalid never depends on tready.
  assign M_axis_tvalid = (state_q != IDLE);
  assign Busy          = (state_q != IDLE);
  assign M_axis_tdata  = tdata_c;
  assign Overrun       = overrun_q;

endmodule

// File: tb/tb_response_encoder.sv
// Bench for response_encoder: two instances (lowercase+write ack, uppercase+no write ack)
// driven by shared stimulus and checked every cycle against a byte-queue reply model.
module tb_response_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, we = 1'b0, ack = 1'b0, tready = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic       va, vu, ba, bu, oa, ou;
  logic [7:0] da, du;

  always #5 clk = ~clk;

  response_encoder dut_a (
    .Clk(clk), .Rst(rst), .Cs(cs), .We(we), .Ack(ack), .Rdata(rdata),
    .M_axis_tvalid(va), .M_axis_tdata(da), .M_axis_tready(tready),
    .Busy(ba), .Overrun(oa)
  );

  response_encoder #(.WORD_SIZE(32), .UPPERCASE(1'b1), .WRITE_ACK(1'b0)) dut_u (
    .Clk(clk), .Rst(rst), .Cs(cs), .We(we), .Ack(ack), .Rdata(rdata),
    .M_axis_tvalid(vu), .M_axis_tdata(du), .M_axis_tready(tready),
    .Busy(bu), .Overrun(ou)
  );

  int checks = 0;
  int errors = 0;

  // Model: each instance owns a queue of bytes still to be sent; head = current tdata.
  logic [7:0] mq [2][$];
  bit         mo [2];
  bit         mbusy [2];
  logic [7:0] cap [2][$];

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    int v;
    v = int'(n);
    if (v < 10) return 8'(48 + v);
    return 8'((up ? 65 : 97) + v - 10);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      mbusy[m] = (mq[m].size() != 0);
      mo[m] = 1'b0;
      if (rst) begin
        mq[m].delete();
      end else begin
        if (mbusy[m] && tready) void'(mq[m].pop_front());
        if (cs && ack) begin
          if (mbusy[m]) mo[m] = 1'b1;
          else if (!we) begin
            for (int i = 7; i >= 0; i--) mq[m].push_back(hexc(rdata[4*i +: 4], m == 1));
            mq[m].push_back(8'h0A);
          end else if (m == 0) begin
            mq[m].push_back(8'h6F);
            mq[m].push_back(8'h6B);
            mq[m].push_back(8'h0A);
          end
        end
      end
    end
    if (!rst && va && tready) cap[0].push_back(da);
    if (!rst && vu && tready) cap[1].push_back(du);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [7:0] ed;
      bit         ev;
      ev = (mq[m].size() != 0);
      ed = ev ? mq[m][0] : 8'h00;
      chk(m == 0 ? "tvalid_a" : "tvalid_u", m == 0 ? 32'(va) : 32'(vu), 32'(ev));
      chk(m == 0 ? "tdata_a"  : "tdata_u",  m == 0 ? 32'(da) : 32'(du), 32'(ed));
      chk(m == 0 ? "busy_a"   : "busy_u",   m == 0 ? 32'(ba) : 32'(bu), 32'(ev));
      chk(m == 0 ? "ovr_a"    : "ovr_u",    m == 0 ? 32'(oa) : 32'(ou), 32'(mo[m]));
    end
  end

  function automatic string qhex(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = $sformatf("%s%02h", s, q[i]);
    return s;
  endfunction

  task automatic check_cap(input string name, input int m, input string exp);
    logic [7:0] e[$];
    bit ok;
    for (int i = 0; i < exp.len(); i++) e.push_back(exp[i]);
    ok = (cap[m].size() == e.size());
    if (ok) foreach (e[i]) if (cap[m][i] !== e[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got bytes %s, expected %s", name, qhex(cap[m]), qhex(e));
    end
  endtask

  task automatic clear_caps();
    cap[0].delete();
    cap[1].delete();
  endtask

  task automatic pulse_done(input bit w, input logic [31:0] d);
    cs = 1'b1; ack = 1'b1; we = w; rdata = d;
    @(negedge clk);
    cs = 1'b0; ack = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((ba || bu) && n < 300) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    tready = 1'b1;
    checks++;
    if (ba || bu) begin
      errors++;
      $display("FAIL wait_idle timeout: busy_a=%0b busy_u=%0b, expected 0", ba, bu);
    end
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    chk("reset_tvalid", 32'(va), 32'h0);
    chk("reset_tdata", 32'(da), 32'h0);
    rst = 1'b0;
    tready = 1'b1;
    @(negedge clk);

    // Read DEADBEEF at full rate: first byte the cycle after the done edge, 9 busy cycles.
    clear_caps();
    pulse_done(1'b0, 32'hDEADBEEF);
    chk("t1_first_valid", 32'(va), 32'h1);
    chk("t1_first_byte", 32'(da), 32'h64);
    bc = 0;
    while (ba && bc < 50) begin
      bc++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(bc), 32'd9);
    check_cap("t1_lower", 0, "deadbeef\n");
    check_cap("t1_upper", 1, "DEADBEEF\n");

    // Write: "ok\n" when acked, nothing at all otherwise.
    clear_caps();
    pulse_done(1'b1, 32'h0);
    chk("t2_ok_valid", 32'(va), 32'h1);
    chk("t2_ok_byte", 32'(da), 32'h6F);
    chk("t2_noack_busy", 32'(bu), 32'h0);
    wait_idle(1'b0);
    check_cap("t2_ok", 0, "ok\n");
    check_cap("t2_none", 1, "");

    // Read with random backpressure.
    clear_caps();
    tready = 1'($urandom_range(0, 1));
    pulse_done(1'b0, 32'h0123ABCD);
    wait_idle(1'b1);
    check_cap("t3_upper", 1, "0123ABCD\n");
    check_cap("t3_lower", 0, "0123abcd\n");

    // Second completion mid-reply is dropped with a one-cycle Overrun.
    clear_caps();
    pulse_done(1'b0, 32'h89ABCDEF);
    @(negedge clk);
    @(negedge clk);
    pulse_done(1'b0, 32'h11111111);
    chk("t4_ovr_a", 32'(oa), 32'h1);
    chk("t4_ovr_u", 32'(ou), 32'h1);
    @(negedge clk);
    chk("t4_ovr_clear", 32'(oa), 32'h0);
    wait_idle(1'b0);
    check_cap("t4_intact", 0, "89abcdef\n");

    // Reset after four bytes abandons the reply; a fresh read then works.
    clear_caps();
    pulse_done(1'b0, 32'hCAFEF00D);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", 32'(va), 32'h0);
    chk("t5_rst_busy", 32'(ba), 32'h0);
    rst = 1'b0;
    check_cap("t5_partial_a", 0, "cafe");
    check_cap("t5_partial_u", 1, "CAFE");
    clear_caps();
    pulse_done(1'b0, 32'h00000000);
    wait_idle(1'b0);
    check_cap("t5_zero", 0, "00000000\n");

    // Rdata changing during a reply has no effect.
    clear_caps();
    pulse_done(1'b0, 32'h12345678);
    rdata = 32'hFFFFFFFF;
    wait_idle(1'b0);
    check_cap("t6_frozen", 0, "12345678\n");

    // Random traffic, including overruns, backpressure and occasional resets.
    repeat (1500) begin
      rst    = ($urandom_range(0, 299) == 0);
      cs     = ($urandom_range(0, 2) == 0);
      ack    = ($urandom_range(0, 2) == 0);
      we     = 1'($urandom_range(0, 1));
      rdata  = $urandom;
      tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst = 1'b0; cs = 1'b0; ack = 1'b0;
    wait_idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
